// File: rtl/edge_pad_handler.sv
// edge_pad_handler
//   Collects an FW x FH filtered image (the median filter output, which is
//   smaller than the full frame by MARGIN on each side) and re-emits it as an
//   IMAGE_WIDTH x IMAGE_HEIGHT frame with the border filled according to a
//   padding mode latched when the last filtered pixel is accepted.
//
// Ports
//   clk, rst_n          : clock (rising edge), async active-low reset
//   filtered_valid/ready/data : raster-order input stream (FW*FH pixels)
//   pad_mode            : 0/3 = zero, 1 = constant pad_value, 2 = replicate
//   pad_value           : constant used in mode 1
//   data_valid_out/ready_out/data_out : registered raster-order output stream
//   data_last           : high with pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1)
//   frame_complete      : one-cycle pulse after the last pixel is accepted
//
// state   | meaning
// COLLECT | accept filtered pixels into the buffer
// OUTPUT  | emit the padded frame, one pixel per downstream handshake
// DONE    | pulse frame_complete, then back to COLLECT
module edge_pad_handler #(
  parameter int WINDOW_SIZE  = 3,
  parameter int IMAGE_WIDTH  = 8,
  parameter int IMAGE_HEIGHT = 8,
  parameter int PIXEL_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   filtered_valid,
  output logic                   filtered_ready,
  input  logic [PIXEL_WIDTH-1:0] filtered_data,
  input  logic [1:0]             pad_mode,
  input  logic [PIXEL_WIDTH-1:0] pad_value,
  output logic                   data_valid_out,
  input  logic                   data_ready_out,
  output logic [PIXEL_WIDTH-1:0] data_out,
  output logic                   data_last,
  output logic                   frame_complete
);

  localparam int MARGIN = (WINDOW_SIZE - 1) / 2;
  localparam int FW     = IMAGE_WIDTH - 2 * MARGIN;
  localparam int FH     = IMAGE_HEIGHT - 2 * MARGIN;
  localparam int NF     = FW * FH;
  localparam int CNT_W  = (NF > 1) ? $clog2(NF) : 1;
  localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
  localparam int COL_W  = $clog2(IMAGE_WIDTH);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NF - 1);
  localparam logic [CNT_W-1:0] FW_C     = CNT_W'(FW);
  localparam logic [ROW_W-1:0] ROW_LO   = ROW_W'(MARGIN);
  localparam logic [ROW_W-1:0] ROW_HI   = ROW_W'(IMAGE_HEIGHT - MARGIN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_LO   = COL_W'(MARGIN);
  localparam logic [COL_W-1:0] COL_HI   = COL_W'(IMAGE_WIDTH - MARGIN - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    OUTPUT  = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [ROW_W-1:0]       out_row_q, out_row_d;
  logic [COL_W-1:0]       out_col_q, out_col_d;
  logic                   loaded_all_q, loaded_all_d;
  logic [1:0]             mode_q, mode_d;
  logic [PIXEL_WIDTH-1:0] pad_val_q, pad_val_d;
  logic                   dv_q, dv_d;
  logic [PIXEL_WIDTH-1:0] dout_q, dout_d;
  logic                   dlast_q, dlast_d;

  logic [PIXEL_WIDTH-1:0] buffer_q [NF];

  logic                   in_hs;
  logic                   out_hs;
  logic                   load;
  logic                   at_end;
  logic                   interior;
  logic [ROW_W-1:0]       rc;
  logic [COL_W-1:0]       cc;
  logic [CNT_W-1:0]       rd_idx;
  logic [PIXEL_WIDTH-1:0] pix;

  assign filtered_ready = (state_q == COLLECT);
  assign in_hs          = filtered_valid && filtered_ready;
  assign out_hs         = dv_q && data_ready_out;
  assign load           = (state_q == OUTPUT) && (!dv_q || data_ready_out) && !loaded_all_q;
  assign at_end         = (out_row_q == ROW_LAST) && (out_col_q == COL_LAST);

  assign data_valid_out = dv_q;
  assign data_out       = dout_q;
  assign data_last      = dlast_q;
  assign frame_complete = (state_q == DONE);

  // Clamping the coordinate into the interior gives the buffer address for
  // interior pixels and for replicate padding alike.
  always_comb begin
    rc = out_row_q;
    if (out_row_q < ROW_LO) rc = ROW_LO;
    else if (out_row_q > ROW_HI) rc = ROW_HI;
    cc = out_col_q;
    if (out_col_q < COL_LO) cc = COL_LO;
    else if (out_col_q > COL_HI) cc = COL_HI;
  end

  assign interior = (out_row_q >= ROW_LO) && (out_row_q <= ROW_HI) &&
                    (out_col_q >= COL_LO) && (out_col_q <= COL_HI);
  assign rd_idx   = CNT_W'(rc - ROW_LO) * FW_C + CNT_W'(cc - COL_LO);

  always_comb begin
    pix = '0;
    if (interior || mode_q == 2'd2) pix = buffer_q[rd_idx];
    else if (mode_q == 2'd1)        pix = pad_val_q;
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    loaded_all_d = loaded_all_q;
    mode_d       = mode_q;
    pad_val_d    = pad_val_q;
    dv_d         = dv_q;
    dout_d       = dout_q;
    dlast_d      = dlast_q;

    case (state_q)
      COLLECT: begin
        if (in_hs) begin
          if (count_q == CNT_MAX) begin
            count_d   = '0;
            mode_d    = pad_mode;
            pad_val_d = pad_value;
            state_d   = OUTPUT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      OUTPUT: begin
        if (out_hs && dlast_q) begin
          dv_d         = 1'b0;
          dlast_d      = 1'b0;
          loaded_all_d = 1'b0;
          state_d      = DONE;
        end else if (load) begin
          dv_d    = 1'b1;
          dout_d  = pix;
          dlast_d = at_end;
          if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            if (out_row_q == ROW_LAST) begin
              out_row_d    = '0;
              loaded_all_d = 1'b1;
            end else begin
              out_row_d = out_row_q + ROW_W'(1);
            end
          end else begin
            out_col_d = out_col_q + COL_W'(1);
          end
        end else if (out_hs) begin
          dv_d = 1'b0;
        end
      end
      DONE: begin
        state_d = COLLECT;
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= COLLECT;
      count_q      <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      loaded_all_q <= 1'b0;
      mode_q       <= 2'd0;
      pad_val_q    <= '0;
      dv_q         <= 1'b0;
      dout_q       <= '0;
      dlast_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      loaded_all_q <= loaded_all_d;
      mode_q       <= mode_d;
      pad_val_q    <= pad_val_d;
      dv_q         <= dv_d;
      dout_q       <= dout_d;
      dlast_q      <= dlast_d;
    end
  end

  // Pixel storage carries no reset; a restarted frame overwrites it from 0.
  always_ff @(posedge clk) begin
    if (in_hs) buffer_q[count_q] <= filtered_data;
  end

endmodule

// File: tb/tb_edge_pad_handler.sv
module tb_edge_pad_handler;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int M    = 1;
  localparam int FW   = W - 2 * M;
  localparam int FH   = H - 2 * M;
  localparam int NF   = FW * FH;
  localparam int NPIX = W * H;

  logic       clk;
  logic       rst_n;
  logic       filtered_valid;
  logic       filtered_ready;
  logic [7:0] filtered_data;
  logic [1:0] pad_mode;
  logic [7:0] pad_value;
  logic       data_valid_out;
  logic       data_ready_out;
  logic [7:0] data_out;
  logic       data_last;
  logic       frame_complete;

  edge_pad_handler #(
    .WINDOW_SIZE (3),
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .PIXEL_WIDTH (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .filtered_valid(filtered_valid),
    .filtered_ready(filtered_ready),
    .filtered_data (filtered_data),
    .pad_mode      (pad_mode),
    .pad_value     (pad_value),
    .data_valid_out(data_valid_out),
    .data_ready_out(data_ready_out),
    .data_out      (data_out),
    .data_last     (data_last),
    .frame_complete(frame_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] in_pix [NF];
  logic [7:0] exp_img [NPIX];
  logic [7:0] cap [NPIX];
  logic [7:0] golden [NPIX];

  int   out_cnt = 0;
  int   fc_cnt = 0;
  int   in_cnt = 0;
  int   first_cd = 0;
  bit   last_hs_prev = 0;
  bit   stall_prev = 0;
  logic [7:0] prev_data = 0;
  logic prev_last = 0;
  int   rdy_mode = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference image: interior pixels come straight from the filtered image;
  // border pixels follow the padding rule.
  function automatic logic [7:0] model_pix(input int r, input int c, input int mode, input logic [7:0] val);
    int  rc, cc;
    bit  border;
    border = (r < M) || (r >= H - M) || (c < M) || (c >= W - M);
    rc = (r < M) ? M : ((r > H - M - 1) ? H - M - 1 : r);
    cc = (c < M) ? M : ((c > W - M - 1) ? W - M - 1 : c);
    if (!border || mode == 2) return in_pix[(rc - M) * FW + (cc - M)];
    if (mode == 1) return val;
    return 8'd0;
  endfunction

  task automatic reset_monitor();
    out_cnt = 0;
    in_cnt = 0;
    first_cd = 0;
    last_hs_prev = 0;
    stall_prev = 0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("frame_complete", frame_complete, last_hs_prev);
      if (last_hs_prev) chk("valid_drop_after_last", data_valid_out, 0);
      if (stall_prev) begin
        chk("stall_data_hold", data_out, prev_data);
        chk("stall_last_hold", data_last, prev_last);
      end
      if (first_cd > 0) begin
        first_cd--;
        if (first_cd == 1) chk("valid_not_early", data_valid_out, 0);
        if (first_cd == 0) chk("first_valid_latency", data_valid_out, 1);
      end
      if (filtered_valid && filtered_ready) begin
        in_cnt++;
        if (in_cnt == NF) begin
          in_cnt = 0;
          first_cd = 2;
        end
      end
      if (data_valid_out) chk("filtered_ready_in_output", filtered_ready, 0);
      if (frame_complete) fc_cnt++;
      if (data_valid_out && data_ready_out) begin
        if (out_cnt >= NPIX) begin
          chk("extra_output", out_cnt, NPIX - 1);
        end else begin
          chk($sformatf("pixel_%0d_%0d", out_cnt / W, out_cnt % W), data_out, exp_img[out_cnt]);
          chk("data_last", data_last, (out_cnt == NPIX - 1) ? 1 : 0);
          cap[out_cnt] = data_out;
          out_cnt++;
        end
      end
      last_hs_prev = data_valid_out && data_ready_out && data_last;
      stall_prev   = data_valid_out && !data_ready_out;
      prev_data    = data_out;
      prev_last    = data_last;
    end
  end

  initial begin
    data_ready_out = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: data_ready_out = 1'b1;
        1: data_ready_out = ~data_ready_out;
        default: data_ready_out = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic prepare(input int mode, input int val, input int kind);
    for (int i = 0; i < NF; i++) begin
      case (kind)
        0: in_pix[i] = 8'(i + 1);
        1: in_pix[i] = 8'(i + 101);
        default: in_pix[i] = 8'($urandom_range(0, 255));
      endcase
    end
    pad_mode  = 2'(mode);
    pad_value = 8'(val);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_img[r * W + c] = model_pix(r, c, mode, 8'(val));
    out_cnt = 0;
  endtask

  task automatic send_pixels(input bit gaps);
    int  i = 0;
    int  guard = 0;
    bit  hs;
    while (i < NF && guard < 5000) begin
      filtered_data  = in_pix[i];
      filtered_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      hs = filtered_valid && filtered_ready;
      @(posedge clk);
      #1;
      if (hs) i++;
      guard++;
    end
    filtered_valid = 1'b0;
    if (i < NF) chk("collect_timeout", i, NF);
  endtask

  task automatic wait_frame(input bit holdv, input bit midchange);
    int g = 0;
    int fc0 = fc_cnt;
    bit hold_now = holdv;
    while (fc_cnt == fc0 && g < 3000) begin
      if (hold_now) begin
        filtered_valid = 1'b1;
        filtered_data  = 8'($urandom_range(0, 255));
      end
      @(posedge clk);
      #1;
      g++;
      if (midchange && out_cnt >= 10) begin
        pad_mode  = 2'd0;
        pad_value = 8'd0;
      end
      if (hold_now && data_last) begin
        hold_now = 0;
        filtered_valid = 1'b0;
      end
    end
    filtered_valid = 1'b0;
    chk("frame_done_pulses", fc_cnt - fc0, 1);
    chk("frame_out_count", out_cnt, NPIX);
  endtask

  task automatic run_frame(input int mode, input int val, input int kind,
                           input bit gaps, input bit midchange, input bit holdv);
    prepare(mode, val, kind);
    send_pixels(gaps);
    wait_frame(holdv, midchange);
  endtask

  initial begin
    rst_n = 1'b0;
    filtered_valid = 1'b0;
    filtered_data = 8'd0;
    pad_mode = 2'd0;
    pad_value = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", data_valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_last", data_last, 0);
    chk("rst_fc", frame_complete, 0);
    chk("rst_fready", filtered_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // zero padding, ascending input
    run_frame(0, 0, 0, 0, 0, 0);
    for (int c = 0; c < W; c++) chk("lit_m0_row0", cap[c], 0);
    for (int c = 0; c < W; c++) chk("lit_m0_row7", cap[7 * W + c], 0);
    chk("lit_m0_1_1", cap[1 * W + 1], 1);
    chk("lit_m0_1_6", cap[1 * W + 6], 6);
    chk("lit_m0_6_6", cap[6 * W + 6], 36);
    for (int i = 0; i < NPIX; i++) golden[i] = cap[i];

    // replicate
    run_frame(2, 0, 0, 0, 0, 0);
    chk("lit_m2_0_0", cap[0], 1);
    chk("lit_m2_0_7", cap[7], 6);
    chk("lit_m2_7_0", cap[7 * W], 31);
    chk("lit_m2_7_7", cap[7 * W + 7], 36);
    chk("lit_m2_0_3", cap[3], 3);
    chk("lit_m2_4_0", cap[4 * W], 19);

    // constant with mode changed during output
    run_frame(1, 8'hFF, 0, 0, 1, 0);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < M || r >= H - M || c < M || c >= W - M)
          chk("lit_m1_border", cap[r * W + c], 8'hFF);

    // toggling ready
    rdy_mode = 1;
    run_frame(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) chk("stall_seq", cap[i], golden[i]);
    rdy_mode = 0;

    // filtered_valid held high through output, then a fresh frame
    run_frame(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < NPIX; i++) chk("holdv_seq", cap[i], golden[i]);
    run_frame(0, 0, 1, 0, 0, 0);
    chk("lit_next_1_1", cap[1 * W + 1], 101);

    // reset after the 20th output
    prepare(0, 0, 1);
    send_pixels(0);
    begin
      int g = 0;
      while (out_cnt < 20 && g < 2000) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (out_cnt < 20) chk("reset_wait_timeout", out_cnt, 20);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", data_valid_out, 0);
    chk("midrst_data", data_out, 0);
    chk("midrst_last", data_last, 0);
    chk("midrst_fc", frame_complete, 0);
    chk("midrst_fready", filtered_ready, 1);
    reset_monitor();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NPIX; i++) chk("post_rst_seq", cap[i], golden[i]);

    // randomized frames
    rdy_mode = 2;
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(0, 3), $urandom_range(0, 255), 2, 1, 0, 0);
    rdy_mode = 0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/edge_pad_handler.md
EDGE_PAD_HANDLER -- requirements
Module: edge_pad_handler

Interface
REQ-001 SHALL have parameter WINDOW_SIZE, default 3: median window size; odd, at least 3, and less than IMAGE_WIDTH and IMAGE_HEIGHT.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 8: output image width in pixels.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 8: output image height in pixels.
REQ-004 SHALL have parameter PIXEL_WIDTH, default 8: pixel width in bits.
REQ-005 SHALL define derived constants: MARGIN=(WINDOW_SIZE-1)/2, FW=IMAGE_WIDTH-2*MARGIN, FH=IMAGE_HEIGHT-2*MARGIN, NF=FW*FH.
REQ-006 SHALL size all counters with $clog2 of their range; no fixed counter widths.
REQ-007 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 Port rst_n, input, 1: asynchronous active-low reset.
REQ-009 Port filtered_valid, input, 1: filtered pixel present.
REQ-010 Port filtered_ready, output, 1: block accepts filtered pixel.
REQ-011 Port filtered_data, input, PIXEL_WIDTH: filtered pixel, raster order.
REQ-012 Port pad_mode, input, 2: 0=zero, 1=constant, 2=replicate, 3=zero.
REQ-013 Port pad_value, input, PIXEL_WIDTH: constant used in mode 1.
REQ-014 Port data_valid_out, output, 1: output pixel valid.
REQ-015 Port data_ready_out, input, 1: downstream accepts pixel.
REQ-016 Port data_out, output, PIXEL_WIDTH: output pixel.
REQ-017 Port data_last, output, 1: high with the final pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
REQ-018 Port frame_complete, output, 1: one-cycle pulse per finished frame.

Function
REQ-019 SHALL implement states COLLECT, OUTPUT and DONE.
REQ-020 COLLECT SHALL drive filtered_ready=1; OUTPUT and DONE SHALL drive it 0.
REQ-021 An input handshake (filtered_valid&&filtered_ready) SHALL write the pixel to buffer[count] and increment count; the buffer depth SHALL be exactly NF.
REQ-022 On the handshake at count==NF-1, the block SHALL clear count, latch pad_mode and pad_value, and enter OUTPUT on the next cycle.
REQ-023 filtered_valid outside COLLECT SHALL be ignored, with no buffer write.
REQ-024 OUTPUT SHALL emit IMAGE_WIDTH*IMAGE_HEIGHT pixels in raster order, tracked by out_row and out_col.
REQ-025 data_out/data_valid_out/data_last SHALL be registers, loaded with the next pixel when data_valid_out==0 or data_ready_out==1; the first pixel SHALL be valid one cycle after entering OUTPUT.
REQ-026 While data_valid_out==1 and data_ready_out==0, data_out and data_last SHALL hold stable.
REQ-027 Interior pixel (MARGIN<=row<IMAGE_HEIGHT-MARGIN and MARGIN<=col<IMAGE_WIDTH-MARGIN) SHALL output buffer[(row-MARGIN)*FW+(col-MARGIN)].
REQ-028 Border pixel SHALL output 0 in modes 0 and 3, and the latched pad_value in mode 1.
REQ-029 In mode 2, a border pixel SHALL output buffer[(rc-MARGIN)*FW+(cc-MARGIN)], where rc=clamp(row,MARGIN,IMAGE_HEIGHT-MARGIN-1) and cc=clamp(col,MARGIN,IMAGE_WIDTH-MARGIN-1).
REQ-030 After the last pixel is loaded, no further pixel SHALL be loaded; when the last pixel is handshaken, data_valid_out SHALL drop on the next cycle and the state SHALL go to DONE.
REQ-031 DONE SHALL pulse frame_complete high for exactly one cycle, then return to COLLECT; frame_complete SHALL be 0 in every other cycle.
REQ-032 pad_mode or pad_value changes during OUTPUT SHALL not affect the current frame.

Reset
REQ-033 rst_n low SHALL immediately force: state=COLLECT, count=0, out_row=0, out_col=0, data_valid_out=0, data_out=0, data_last=0, frame_complete=0.
REQ-034 Reset mid-frame SHALL discard partial buffer contents logically; the next frame SHALL collect NF fresh pixels.
REQ-035 Buffer contents SHALL need no reset.

Verification
REQ-036 Defaults, mode 0, input 1..36 -> 64 outputs; row 0 all 0; (1,1)=1; (1,6)=6; (6,6)=36; (7,x)=0; data_last only on 64th; one frame_complete pulse.
REQ-037 Mode 2, input 1..36 -> (0,0)=1, (0,7)=6, (7,0)=31, (7,7)=36, (0,3)=3, (4,0)=19.
REQ-038 Mode 1, pad_value=0xFF, pad_mode changed to 0 mid-OUTPUT -> all 28 border pixels =0xFF.
REQ-039 data_ready_out toggling 1,0,1,0 -> data_out stable while stalled; the 64-pixel sequence is identical to REQ-036.
REQ-040 filtered_valid held high through OUTPUT -> filtered_ready=0 and output unchanged; the next frame, input 101..136, outputs (1,1)=101.
REQ-041 rst_n pulsed after the 20th output -> all outputs 0 immediately; the next full frame is correct per REQ-036.
